// File: rtl/parking_sensor_emulator.sv
// Two-beam (a,b) parking sensor waveform generator; plays queued enter/exit
// requests as complete Gray-coded passes for the parking lot counter.
//   state | meaning
//   IDLE  | ab=00, waiting for a pending request
//   PH1   | first beam broken (enter 10, exit 01)
//   PH2   | both beams broken (11)
//   PH3   | second beam only (enter 01, exit 10)
//   GAP   | ab=00 spacer after each car, car_done in its first cycle
module parking_sensor_emulator #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enter_req,
  input  logic             exit_req,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             car_done,
  output logic             done_dir,
  output logic [CNT_W-1:0] enter_pend,
  output logic [CNT_W-1:0] exit_pend,
  output logic             overflow
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PH1  = 3'd1;
  localparam logic [2:0] S_PH2  = 3'd2;
  localparam logic [2:0] S_PH3  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]       state, state_nx;
  logic [TMR_W-1:0] timer, timer_nx;
  logic             dir, dir_nx;
  logic             prio_enter;
  logic             pick_any, pick_enter, start;
  logic             deq_en, deq_ex;
  logic [1:0]       ab_nx;

  assign pick_any   = (enter_pend != '0) || (exit_pend != '0);
  assign pick_enter = (enter_pend != '0) && ((exit_pend == '0) || prio_enter);

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    dir_nx   = dir;
    start    = 1'b0;
    case (state)
      S_IDLE: start = pick_any;
      S_PH1, S_PH2, S_PH3: begin
        if (timer == '0) begin
          state_nx = (state == S_PH3) ? S_GAP : state + 3'd1;
          timer_nx = (state == S_PH3) ? GAP_LD : HOLD_LD;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      S_GAP: begin
        if (timer == '0) begin
          if (pick_any) start = 1'b1;
          else          state_nx = S_IDLE;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (start) begin
      state_nx = S_PH1;
      timer_nx = HOLD_LD;
      dir_nx   = pick_enter;
    end
    deq_en = start && pick_enter;
    deq_ex = start && !pick_enter;
  end

  // ab is registered from the next state so it lines up with the state it describes
  always_comb begin
    case (state_nx)
      S_PH1:   ab_nx = dir_nx ? 2'b10 : 2'b01;
      S_PH2:   ab_nx = 2'b11;
      S_PH3:   ab_nx = dir_nx ? 2'b01 : 2'b10;
      default: ab_nx = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      dir        <= 1'b0;
      prio_enter <= 1'b1;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      car_done   <= 1'b0;
      done_dir   <= 1'b0;
      enter_pend <= '0;
      exit_pend  <= '0;
      overflow   <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      dir      <= dir_nx;
      {a, b}   <= ab_nx;
      busy     <= (state_nx != S_IDLE);
      car_done <= (state_nx == S_GAP) && (state != S_GAP);
      if ((state_nx == S_GAP) && (state != S_GAP)) done_dir <= dir;
      if (start) prio_enter <= !pick_enter;

      if (enter_req && !deq_en) begin
        if (enter_pend == CNT_MAX) overflow <= 1'b1;
        else                       enter_pend <= enter_pend + 1'b1;
      end else if (deq_en && !enter_req) begin
        enter_pend <= enter_pend - 1'b1;
      end

      if (exit_req && !deq_ex) begin
        if (exit_pend == CNT_MAX) overflow <= 1'b1;
        else                      exit_pend <= exit_pend + 1'b1;
      end else if (deq_ex && !exit_req) begin
        exit_pend <= exit_pend - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parking_sensor_emulator.sv
// Self-checking bench: directed timing checks plus a done_dir scoreboard
// fed when requests are driven and drained on every car_done.
module tb_parking_sensor_emulator;

  localparam int H = 4;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst, enter_req, exit_req;
  logic a, b, busy, car_done, done_dir, overflow;
  logic [3:0] enter_pend, exit_pend;

  logic enter_req2;
  logic a2, b2, busy2, car_done2, done_dir2, overflow2;
  logic [1:0] enter_pend2, exit_pend2;

  int n_chk = 0;
  int n_err = 0;
  int done2_cnt = 0;
  bit sb[$];

  always #5 clk = ~clk;

  parking_sensor_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .enter_req(enter_req), .exit_req(exit_req),
    .a(a), .b(b), .busy(busy), .car_done(car_done), .done_dir(done_dir),
    .enter_pend(enter_pend), .exit_pend(exit_pend), .overflow(overflow)
  );

  parking_sensor_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .enter_req(enter_req2), .exit_req(1'b0),
    .a(a2), .b(b2), .busy(busy2), .car_done(car_done2), .done_dir(done_dir2),
    .enter_pend(enter_pend2), .exit_pend(exit_pend2), .overflow(overflow2)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loop-back monitor: decodes direction from the ab pattern and checks Gray steps
  logic [1:0] prev_ab = 2'b00;
  logic prev_rst = 1'b1;
  logic first_dir = 1'b0;
  always @(negedge clk) begin
    if (!prev_rst && !rst && ({a, b} != prev_ab))
      check_val("gray_step", $countones({a, b} ^ prev_ab), 1);
    if (prev_ab == 2'b00 && {a, b} != 2'b00) first_dir = ({a, b} == 2'b10);
    if (car_done && !rst) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", sb.size(), 1);
      end else begin
        bit e;
        e = sb.pop_front();
        check_val("done_dir", done_dir, e);
        check_val("decoded_dir", first_dir, e);
      end
    end
    if (car_done2) done2_cnt++;
    prev_ab  = {a, b};
    prev_rst = rst;
  end

  function automatic logic [1:0] exp_ab(input int c, input bit ent);
    if (c >= 2 && c < 2 + H)          return ent ? 2'b10 : 2'b01;
    if (c >= 2 + H && c < 2 + 2*H)    return 2'b11;
    if (c >= 2 + 2*H && c < 2 + 3*H)  return ent ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic single_car(input bit ent);
    sb.push_back(ent);
    if (ent) enter_req = 1'b1; else exit_req = 1'b1;
    for (int c = 1; c <= 2 + 3*H + G + 3; c++) begin
      tick();
      enter_req = 1'b0;
      exit_req  = 1'b0;
      check_val(ent ? "ent_ab" : "ext_ab", {a, b}, exp_ab(c, ent));
      check_val("busy", busy, (c >= 2 && c < 2 + 3*H + G));
      check_val("car_done", car_done, (c == 2 + 3*H));
      if (c == 1) check_val("pend_c1", ent ? enter_pend : exit_pend, 1);
      if (c == 2) check_val("pend_c2", ent ? enter_pend : exit_pend, 0);
    end
  endtask

  initial begin
    rst = 1'b1; enter_req = 1'b0; exit_req = 1'b0; enter_req2 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_val("rst_ab", {a, b}, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", {car_done, done_dir}, 0);
    check_val("rst_pend", {enter_pend, exit_pend}, 0);
    check_val("rst_ovf", overflow, 0);
    check_val("rst_pend2", {enter_pend2, overflow2}, 0);

    // single enter car, then single exit car
    single_car(1'b1);
    single_car(1'b0);

    // simultaneous enter+exit: back-to-back cars
    sb.push_back(1'b1); sb.push_back(1'b0);
    enter_req = 1'b1; exit_req = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      tick();
      enter_req = 1'b0; exit_req = 1'b0;
      check_val("both_busy", busy, (c >= 2 && c <= 29));
      check_val("both_done", car_done, (c == 14 || c == 28));
      if (c == 16) check_val("both_x_ph1", {a, b}, 2'b01);
      if (c == 15) check_val("both_gap", {a, b}, 2'b00);
    end

    // reset during enter PH2 aborts the car
    enter_req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      enter_req = 1'b0;
    end
    check_val("pre_rst_ab", {a, b}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("abort_ab", {a, b}, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_pend", {enter_pend, exit_pend}, 0);
    check_val("abort_ovf", overflow, 0);
    for (int c = 0; c < 20; c++) begin
      tick();
      check_val("abort_idle", {busy, car_done}, 0);
    end

    // two of each queued: alternating service E,X,E,X
    sb.push_back(1'b1); sb.push_back(1'b0); sb.push_back(1'b1); sb.push_back(1'b0);
    enter_req = 1'b1; exit_req = 1'b1;
    tick();
    tick();
    enter_req = 1'b0; exit_req = 1'b0;
    check_val("alt_pend_e", enter_pend, 1);
    check_val("alt_pend_x", exit_pend, 2);
    for (int c = 0; c < 200 && (sb.size() != 0 || busy); c++) tick();
    check_val("sb_drain", sb.size(), 0);
    check_val("alt_idle", busy, 0);
    check_val("no_ovf", overflow, 0);

    // narrow counter overflow on the CNT_W=2 instance
    done2_cnt = 0;
    enter_req2 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 5) enter_req2 = 1'b0;
      case (c)
        1: check_val("ovf_pend_c1", enter_pend2, 1);
        2: check_val("ovf_pend_c2", enter_pend2, 1);
        3: check_val("ovf_pend_c3", enter_pend2, 2);
        4: check_val("ovf_pend_c4", enter_pend2, 3);
        default: ;
      endcase
      check_val("ovf_flag", overflow2, (c == 5));
    end
    for (int c = 0; c < 200 && busy2; c++) tick();
    repeat (5) tick();
    check_val("ovf_cars", done2_cnt, 4);
    check_val("ovf_sticky", overflow2, 1);
    check_val("ovf_dir", done_dir2, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
